// File: rtl/myproject_mac_pipe_dsp.sv
//------------------------------------------------------------------------------
// myproject_mac_pipe_dsp
//
// Pipelined signed multiply-accumulate unit for dense/conv layer kernels.
// It sits between a weight/activation streamer and the layer output buffer.
// Each accepted beat multiplies din0*din1 at full precision. The product then
// either passes straight through or is summed into an ACC_WIDTH accumulator
// over a group of beats framed by acc_first/acc_last. Each result is narrowed
// to DOUT_WIDTH, by clamping (SATURATE=1) or by keeping the low bits
// (SATURATE=0).
//
// Pipeline (NUM_STAGE cycles of latency in total):
//   p0 : input register (operands + group flags)
//   p1 : NUM_STAGE-2 product registers (absent when NUM_STAGE == 2)
//   p2 : accumulator / output register
// All stages shift together on advance = ce & (~out_valid | out_ready).
// A stalled or clock-disabled unit therefore holds every stage, including
// the presented output.
//
// Ports:
//   ap_clk, ap_rst_n      clock (rising edge); asynchronous active-low reset
//   ce                    clock enable; 0 freezes all state, in_ready=0
//   in_valid / in_ready   input handshake; in_ready is combinational
//   din0, din1            signed operands (activation, weight)
//   acc_en                1: beat is part of an accumulation group
//   acc_first, acc_last   group framing (load / emit)
//   out_valid / out_ready output handshake
//   dout                  signed narrowed result
//   sat_flag              dout was clamped (always 0 when SATURATE=0)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module myproject_mac_pipe_dsp #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int ACC_WIDTH  = 32,
    parameter int DOUT_WIDTH = 26,
    parameter int NUM_STAGE  = 3,
    parameter int SATURATE   = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    input  logic                         acc_en,
    input  logic                         acc_first,
    input  logic                         acc_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         sat_flag
);

    localparam int PROD_WIDTH   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int NUM_PROD_REG = NUM_STAGE - 2;

    // Elaboration-time sanity checks on the parameter set.
    if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_acc_width
        $error("ACC_WIDTH must be >= DIN0_WIDTH + DIN1_WIDTH");
    end
    if (DOUT_WIDTH > ACC_WIDTH || DOUT_WIDTH < 2) begin : g_bad_dout_width
        $error("DOUT_WIDTH must be in [2, ACC_WIDTH]");
    end
    if (NUM_STAGE < 2) begin : g_bad_num_stage
        $error("NUM_STAGE must be >= 2");
    end

    // Full-precision signed product, sign-extended to the accumulator width.
    // Both operands are widened to PROD_WIDTH first, so the multiply cannot
    // lose bits.
    function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
        input logic signed [DIN0_WIDTH-1:0] a,
        input logic signed [DIN1_WIDTH-1:0] b
    );
        logic signed [PROD_WIDTH-1:0] a_w;
        logic signed [PROD_WIDTH-1:0] b_w;
        logic signed [PROD_WIDTH-1:0] p;
        a_w     = PROD_WIDTH'(a);
        b_w     = PROD_WIDTH'(b);
        p       = a_w * b_w;
        mul_ext = ACC_WIDTH'(p);
    endfunction

    // Narrow an accumulator-width value to DOUT_WIDTH. The result is
    // {clamped, value}. The value fits exactly when every bit from the output
    // sign position upward is identical. DOUT_WIDTH == ACC_WIDTH leaves a
    // one-bit slice, so the value always fits and is copied unchanged.
    function automatic logic [DOUT_WIDTH:0] narrow(
        input logic signed [ACC_WIDTH-1:0] res
    );
        logic [ACC_WIDTH-DOUT_WIDTH:0] top;
        logic                          fits;
        top  = res[ACC_WIDTH-1:DOUT_WIDTH-1];
        fits = (&top) | ~(|top);
        if (SATURATE != 0 && !fits) begin
            narrow = res[ACC_WIDTH-1] ? {1'b1, 1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                      : {1'b1, 1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end else begin
            narrow = {1'b0, res[DOUT_WIDTH-1:0]};
        end
    endfunction

    logic advance;

    assign advance  = ce & (~out_valid | out_ready);
    assign in_ready = advance;

    // ---------------- stage p0: input register ----------------
    logic                         vld_p0;
    logic signed [DIN0_WIDTH-1:0] din0_p0;
    logic signed [DIN1_WIDTH-1:0] din1_p0;
    logic [2:0]                   ctl_p0;      // {acc_en, acc_first, acc_last}
    logic signed [ACC_WIDTH-1:0]  prod_p0;     // product formed from p0 regs

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_p0 <= 1'b0;
        end else if (advance) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (advance) begin
            din0_p0 <= din0;
            din1_p0 <= din1;
            ctl_p0  <= {acc_en, acc_first, acc_last};
        end
    end

    assign prod_p0 = mul_ext(din0_p0, din1_p0);

    // ---------------- stage p1: product registers ----------------
    // The beat that reaches the acc/out stage; the flags travel with the
    // product and are only looked at when the valid bit is set.
    logic                        vld_fin;
    logic signed [ACC_WIDTH-1:0] prod_fin;
    logic [2:0]                  ctl_fin;

    if (NUM_PROD_REG == 0) begin : g_no_prod_reg
        assign vld_fin  = vld_p0;
        assign prod_fin = prod_p0;
        assign ctl_fin  = ctl_p0;
    end else begin : g_prod_reg
        logic [NUM_PROD_REG-1:0]     vld_p1;
        logic signed [ACC_WIDTH-1:0] prod_p1 [NUM_PROD_REG];
        logic [2:0]                  ctl_p1  [NUM_PROD_REG];

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                vld_p1 <= '0;
            end else if (advance) begin
                vld_p1[0] <= vld_p0;
                for (int i = 1; i < NUM_PROD_REG; i++) begin
                    vld_p1[i] <= vld_p1[i-1];
                end
            end
        end

        always_ff @(posedge ap_clk) begin
            if (advance) begin
                prod_p1[0] <= prod_p0;
                ctl_p1[0]  <= ctl_p0;
                for (int i = 1; i < NUM_PROD_REG; i++) begin
                    prod_p1[i] <= prod_p1[i-1];
                    ctl_p1[i]  <= ctl_p1[i-1];
                end
            end
        end

        assign vld_fin  = vld_p1[NUM_PROD_REG-1];
        assign prod_fin = prod_p1[NUM_PROD_REG-1];
        assign ctl_fin  = ctl_p1[NUM_PROD_REG-1];
    end

    // ---------------- stage p2: accumulator / output register ----------------
    logic signed [ACC_WIDTH-1:0]  acc_p2;
    logic signed [ACC_WIDTH-1:0]  acc_sum;
    logic signed [ACC_WIDTH-1:0]  acc_nxt;
    logic signed [ACC_WIDTH-1:0]  res;
    logic                         emit;
    logic                         en_fin;
    logic                         first_fin;
    logic                         last_fin;
    logic signed [DOUT_WIDTH-1:0] nar_val;
    logic                         nar_flag;

    assign en_fin    = ctl_fin[2];
    assign first_fin = ctl_fin[1];
    assign last_fin  = ctl_fin[0];

    // A pass-through beat inside an open group keeps acc_nxt = acc_p2, so
    // the group continues untouched after it. Bubbles never emit.
    always_comb begin
        acc_sum = acc_p2 + prod_fin;
        acc_nxt = acc_p2;
        res     = prod_fin;
        emit    = 1'b0;
        if (vld_fin) begin
            if (!en_fin) begin
                emit = 1'b1;
            end else if (first_fin) begin
                acc_nxt = prod_fin;
                emit    = last_fin;
            end else begin
                acc_nxt = acc_sum;
                res     = acc_sum;
                emit    = last_fin;
            end
        end
        {nar_flag, nar_val} = narrow(res);
    end

    // dout/sat_flag are only loaded on an emit. A non-emitting advance drops
    // out_valid and leaves the stale value behind it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_p2    <= '0;
            out_valid <= 1'b0;
            dout      <= '0;
            sat_flag  <= 1'b0;
        end else if (advance) begin
            acc_p2    <= acc_nxt;
            out_valid <= emit;
            if (emit) begin
                dout     <= nar_val;
                sat_flag <= nar_flag;
            end
        end
    end

endmodule
